operand_sweep: RTL and testbench
================================

OPERAND_SWEEP -- requirements
Module: operand_sweep

Interface
REQ-001 SHALL have parameter SETTLE, default 2, giving cycles operands are held before results are sampled (legal range 1..15).
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous active-high reset.
REQ-004 SHALL have port start  input  1  begin one full sweep; sampled only in IDLE.
REQ-005 SHALL have port abort  input  1  synchronous abandon of sweep in progress.
REQ-006 SHALL have port a  output  2  operand A driven to the downstream arithmetic unit.
REQ-007 SHALL have port b  output  2  operand B driven to the downstream arithmetic unit.
REQ-008 SHALL have port sum_in  input  3  sum result returned by the arithmetic unit.
REQ-009 SHALL have port mult_in  input  3  product result returned by the arithmetic unit.
REQ-010 SHALL have port abb_in  input  3  third result returned by the arithmetic unit.
REQ-011 SHALL have port res_valid  output  1  result record available.
REQ-012 SHALL have port res_ready  input  1  consumer accepts record this cycle.
REQ-013 SHALL have port res_data  output  13  record {a,b,sum_in,mult_in,abb_in}, MSB first.
REQ-014 SHALL have port res_last  output  1  marks record of final pair (a=3,b=3).
REQ-015 SHALL have port busy  output  1  high in DRIVE, CAPT, DONE.
REQ-016 SHALL have port done  output  1  one-cycle pulse at end of a completed sweep.

Function
REQ-017 SHALL implement states IDLE, DRIVE, CAPT, DONE with 4-bit pair index idx and settle counter cnt.
REQ-018 SHALL drive a=idx[3:2], b=idx[1:0] in every state; idx=0 in IDLE.
REQ-019 IDLE: start=1 -> DRIVE, idx=0, cnt=0; otherwise remain.
REQ-020 DRIVE: cnt increments each cycle; at cnt==SETTLE-1 -> CAPT.
REQ-021 CAPT: when output slot free (res_valid==0 or res_ready==1), load res_data from current a,b and inputs, set res_valid=1, res_last=(idx==15).
REQ-022 CAPT after load: idx==15 -> DONE; else idx<=idx+1, cnt<=0, -> DRIVE.
REQ-023 CAPT with slot occupied and res_ready==0 SHALL stall in CAPT, holding a, b, idx, res_data unchanged.
REQ-024 DONE SHALL assert done for exactly one cycle, then -> IDLE.
REQ-025 res_valid SHALL clear on res_valid&res_ready when no new load occurs in the same cycle; a simultaneous accept and load SHALL leave res_valid=1 with new data.
REQ-026 res_data and res_last SHALL remain stable while res_valid=1 and res_ready=0.
REQ-027 Per-pair period with res_ready held 1 SHALL be SETTLE+1 cycles; full sweep 16*(SETTLE+1) cycles from start to DONE entry.
REQ-028 start while busy SHALL be ignored.
REQ-029 abort=1 in any non-IDLE state SHALL go to IDLE next cycle, idx=0, res_valid=0, res_last=0, no done pulse; abort takes priority over start and loads.
REQ-030 idx SHALL NOT wrap past 15; a new sweep requires a new start.

Reset
REQ-031 rst=1 SHALL, at the next edge, force IDLE, idx=0, cnt=0, a=0, b=0, res_valid=0, res_data=0, res_last=0, busy=0, done=0, with priority over abort and start.
REQ-032 rst asserted mid-sweep SHALL discard any pending record without a done pulse.

Verification
REQ-033 SETTLE=2, res_ready=1, inputs from model (sum=a+b): start pulse -> 16 records, idx order 0..15, first res_data={00,00,...}, res_last only on 16th, done one cycle 48 cycles after start.
REQ-034 Backpressure: res_ready=0 for 10 cycles after first record -> res_valid stays 1, res_data unchanged, a/b frozen at pair 1; release -> sweep resumes, no record lost or duplicated.
REQ-035 Record format: a=3,b=1 with sum_in=3'b100, mult_in=3'b011, abb_in=3'b010 -> res_data=13'b11_01_100_011_010.
REQ-036 abort during pair 7 -> next cycle IDLE, a=b=0, res_valid=0, done never pulses; subsequent start restarts at pair 0.
REQ-037 rst during CAPT stall -> all outputs 0 next cycle; start while busy produces no restart.

Source files
------------

// File: rtl/operand_sweep.sv
// Steps (a,b) through all 16 pairs, holding each pair SETTLE cycles and then capturing the results.
// Latency: SETTLE+1 cycles per pair. Backpressure: the sweep stalls in CAPT while a record sits unaccepted.
module operand_sweep #(
   parameter int SETTLE = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        abort,
   output logic [1:0]  a,
   output logic [1:0]  b,
   input  logic [2:0]  sum_in,
   input  logic [2:0]  mult_in,
   input  logic [2:0]  abb_in,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [12:0] res_data,
   output logic        res_last,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {IDLE, DRIVE, CAPT, DONE} state_t;

   localparam logic [3:0] LAST_CNT = 4'(SETTLE - 1);

   state_t     state, state_nxt;
   logic [3:0] idx;
   logic [3:0] cnt;
   logic       slot_free;
   logic       kill;
   logic       load;

   assign slot_free = !res_valid || res_ready;
   assign kill      = abort && (state != IDLE);
   assign load      = (state == CAPT) && slot_free && !abort;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (kill) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (start && !abort) state_nxt = DRIVE;
            DRIVE:   if (cnt == LAST_CNT) state_nxt = CAPT;
            CAPT:    if (slot_free) state_nxt = (idx == 4'd15) ? DONE : DRIVE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      a    = idx[3:2];
      b    = idx[1:0];
      busy = (state != IDLE);
      done = (state == DONE);
   end

   // Pair index, settle counter and the one-deep result slot.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx       <= '0;
         cnt       <= '0;
         res_valid <= 1'b0;
         res_data  <= '0;
         res_last  <= 1'b0;
      end else if (kill) begin
         idx       <= '0;
         cnt       <= '0;
         res_valid <= 1'b0;
         res_last  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               idx <= '0;
               cnt <= '0;
            end
            DRIVE: cnt <= cnt + 4'd1;
            CAPT: begin
               if (slot_free) begin
                  cnt <= '0;
                  if (idx != 4'd15) idx <= idx + 4'd1;
               end
            end
            DONE:    idx <= '0;
            default: idx <= '0;
         endcase

         // An accept in the same cycle as a load leaves the slot full with the new record.
         if (load) begin
            res_valid <= 1'b1;
            res_data  <= {a, b, sum_in, mult_in, abb_in};
            res_last  <= (idx == 4'd15);
         end else if (res_valid && res_ready) begin
            res_valid <= 1'b0;
            res_last  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_operand_sweep.sv
// Directed bench for operand_sweep: full sweep, backpressure, record packing, abort and reset.
module tb_operand_sweep;

   logic        clk = 1'b0;
   logic        rst, start, abort, res_ready, ovr;
   logic [1:0]  a, b;
   logic [2:0]  sum_in, mult_in, abb_in;
   logic        res_valid, res_last, busy, done;
   logic [12:0] res_data;
   logic [3:0]  prod;

   int n_cmp = 0;
   int n_err = 0;

   operand_sweep #(.SETTLE(2)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .a(a), .b(b), .sum_in(sum_in), .mult_in(mult_in), .abb_in(abb_in),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .res_last(res_last), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Arithmetic unit stub: sum, truncated product, xor.
   always_comb begin
      prod = {2'b00, a} * {2'b00, b};
      if (ovr) begin
         sum_in  = 3'b100;
         mult_in = 3'b011;
         abb_in  = 3'b010;
      end else begin
         sum_in  = {1'b0, a} + {1'b0, b};
         mult_in = prod[2:0];
         abb_in  = {1'b0, a ^ b};
      end
   end

   function automatic logic [12:0] rec_exp(input int i);
      logic [1:0] ai, bi;
      logic [2:0] s;
      logic [3:0] p;
      ai = 2'(i >> 2);
      bi = 2'(i & 3);
      s  = {1'b0, ai} + {1'b0, bi};
      p  = {2'b00, ai} * {2'b00, bi};
      return {ai, bi, s, p[2:0], 1'b0, ai ^ bi};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input string tag, input int max);
      int k;
      k = 0;
      while (!res_valid && k < max) begin
         tick();
         k++;
      end
      check(tag, res_valid, 1);
   endtask

   initial begin
      int rec, dcnt, dcyc, k;

      rst = 1'b1; start = 1'b0; abort = 1'b0; res_ready = 1'b1; ovr = 1'b0;
      tick();
      tick();
      rst = 1'b0;

      // Reset state
      check("rst_valid", res_valid, 0);
      check("rst_busy",  busy, 0);
      check("rst_done",  done, 0);
      check("rst_ab",    {a, b}, 0);
      check("rst_data",  res_data, 0);
      check("rst_last",  res_last, 0);

      // Full sweep with a start pulse mid-sweep that must be ignored
      start = 1'b1;
      tick();
      start = 1'b0;
      rec = 0; dcnt = 0; dcyc = -1;
      for (int c = 1; c <= 60; c++) begin
         if (c == 20) start = 1'b1;
         if (c == 21) start = 1'b0;
         tick();
         if (res_valid) begin
            if (rec < 16) begin
               check("sweep_data", res_data, rec_exp(rec));
               check("sweep_last", res_last, (rec == 15));
            end
            rec++;
         end
         if (done) begin
            dcnt++;
            dcyc = c;
         end
      end
      check("sweep_nrec",  rec, 16);
      check("sweep_ndone", dcnt, 1);
      check("sweep_dcyc",  dcyc, 48);
      check("sweep_idle",  busy, 0);

      // Backpressure after the first record
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_valid("bp_first", 20);
      check("bp_first_data", res_data, rec_exp(0));
      res_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("bp_hold_valid", res_valid, 1);
         check("bp_hold_data",  res_data, rec_exp(0));
         check("bp_hold_ab",    {a, b}, 4'd1);
      end
      res_ready = 1'b1;
      rec = 1; dcnt = 0;
      for (int i = 0; i < 100 && dcnt == 0; i++) begin
         tick();
         if (res_valid) begin
            if (rec < 16) check("bp_data", res_data, rec_exp(rec));
            rec++;
         end
         if (done) dcnt++;
      end
      check("bp_nrec",  rec, 16);
      check("bp_ndone", dcnt, 1);
      tick();

      // Record packing for a=3, b=1
      ovr = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      rec = 0;
      for (int c = 0; c < 60; c++) begin
         tick();
         if (res_valid) begin
            if (rec == 13) check("fmt_31", res_data, 13'b11_01_100_011_010);
            rec++;
         end
      end
      check("fmt_nrec", rec, 16);
      ovr = 1'b0;

      // Abort during pair 7
      start = 1'b1;
      tick();
      start = 1'b0;
      k = 0;
      while (!(busy && a == 2'd1 && b == 2'd3) && k < 100) begin
         tick();
         k++;
      end
      check("ab_reach7", {a, b}, 4'd7);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("ab_busy",  busy, 0);
      check("ab_ab",    {a, b}, 0);
      check("ab_valid", res_valid, 0);
      check("ab_last",  res_last, 0);
      dcnt = 0;
      for (int i = 0; i < 60; i++) begin
         if (done) dcnt++;
         tick();
      end
      check("ab_nodone", dcnt, 0);
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_valid("ab_restart", 20);
      check("ab_restart_data", res_data, rec_exp(0));

      rst = 1'b1;
      tick();
      rst = 1'b0;

      // Reset during a CAPT stall
      res_ready = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_valid("rs_first", 20);
      for (int i = 0; i < 5; i++) tick();
      check("rs_stall_busy", busy, 1);
      check("rs_stall_ab",   {a, b}, 4'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rs_valid", res_valid, 0);
      check("rs_data",  res_data, 0);
      check("rs_last",  res_last, 0);
      check("rs_ab",    {a, b}, 0);
      check("rs_busy",  busy, 0);
      check("rs_done",  done, 0);
      dcnt = 0;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (done || busy) dcnt++;
      end
      check("rs_quiet", dcnt, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
